multicycle_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that computes a WIDTH-bit sum or difference CHUNK bits per clock, LSB chunk first, with a registered carry between chunks. It generalises the single-bit adder cells in the combinational adder library into a sequential datapath with valid/ready handshakes on both sides. It is the building block for area-constrained arithmetic paths where a full-width carry chain in one cycle is too slow or too large.

---
 rtl/multicycle_adder_if.sv | 26 ++
 rtl/multicycle_adder.sv | 111 +++++++++++
 tb/tb_multicycle_adder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_adder_if.sv
// Handshake bundle for multicycle_adder: operand side (in_*) and result side (out_*).
interface multicycle_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/multicycle_adder.sv
// Sequential adder/subtractor: WIDTH-bit result built CHUNK bits per cycle, LSB chunk first,
// with the carry held in a register between chunks.
module multicycle_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic               clk,
    input logic               rst,
    multicycle_adder_if.slave bus
);
    localparam int unsigned N  = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 2) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("multicycle_adder: WIDTH must be >= 2 and an integer multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic [31:0]      base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    logic [WIDTH-1:0] acc_final;
    logic             ovf_final;
    logic             last;

    // One chunk of the ripple: select chunk cnt, add with the registered carry, merge into acc.
    always_comb begin
        base       = 32'(cnt) * CHUNK;
        a_chunk    = CHUNK'(opa >> base);
        b_chunk    = CHUNK'(opb >> base);
        {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry);
        acc_final  = (acc & ~(WIDTH'({CHUNK{1'b1}}) << base)) | (WIDTH'(s_chunk) << base);
        // opb is already inverted for subtract, so one rule covers both modes
        ovf_final  = (opa[WIDTH-1] == opb[WIDTH-1]) && (acc_final[WIDTH-1] != opa[WIDTH-1]);
        last       = (cnt == IW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            opa         <= '0;
            opb         <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opa   <= bus.a;
                        opb   <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub ? ~bus.cin : bus.cin;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_final;
                    carry <= c_chunk;
                    if (last) begin
                        sum_q       <= acc_final;
                        cout_q      <= c_chunk;
                        ovf_q       <= ovf_final;
                        out_valid_q <= 1'b1;
                        cnt         <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// Directed and randomised checks of multicycle_adder at CHUNK=4, 16 and 1 (WIDTH=16).
module tb_multicycle_adder;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         in_valid    [3];
    logic         out_ready   [3];
    logic         in_ready_o  [3];
    logic         out_valid_o [3];
    logic         cout_o      [3];
    logic         ovf_o       [3];
    logic [W-1:0] sum_o       [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int unsigned CK = (k == 0) ? 4 : ((k == 1) ? 16 : 1);
        multicycle_adder_if #(.WIDTH(W)) bus ();
        assign bus.in_valid   = in_valid[k];
        assign bus.out_ready  = out_ready[k];
        assign bus.a          = a;
        assign bus.b          = b;
        assign bus.sub        = sub;
        assign bus.cin        = cin;
        assign in_ready_o[k]  = bus.in_ready;
        assign out_valid_o[k] = bus.out_valid;
        assign sum_o[k]       = bus.sum;
        assign cout_o[k]      = bus.cout;
        assign ovf_o[k]       = bus.overflow;
        multicycle_adder #(.WIDTH(W), .CHUNK(CK)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    endfunction

    // Reference: {overflow, cout, sum} from full-width integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic ms, input logic mc);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ov;
        bb   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + 17'(ms ? !mc : mc);
        ov   = (ma[15] == bb[15]) && (full[15] != ma[15]);
        return {ov, full[16], full[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k);
        int t;
        t = 0;
        while (!in_ready_o[k] && t < 100) begin
            tick();
            t++;
        end
        check("in_ready_wait", 32'(in_ready_o[k]), 32'd1);
    endtask

    task automatic wait_valid(input int k, inout int lat);
        while (!out_valid_o[k] && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    // Issue one operation, wait for result, hold backpressure for hold cycles, then drain.
    task automatic run_op(input int k, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, input logic tc, input int hold,
                          output logic [15:0] rs, output logic rc, output logic ro, output int lat);
        wait_ready(k);
        a = ta; b = tb_v; sub = ts; cin = tc;
        in_valid[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        wait_valid(k, lat);
        rs = sum_o[k]; rc = cout_o[k]; ro = ovf_o[k];
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_stable", {13'd0, out_valid_o[k], cout_o[k], ovf_o[k], sum_o[k]},
                  {13'd0, 1'b1, rc, ro, rs});
        end
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        check("drain_out_valid", 32'(out_valid_o[k]), 32'd0);
        check("drain_in_ready", 32'(in_ready_o[k]), 32'd1);
    endtask

    task automatic directed(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                            input logic ts, input logic tc,
                            input logic [15:0] es, input logic ec, input logic eo);
        logic [15:0] rs;
        logic        rc;
        logic        ro;
        int          lat;
        run_op(0, ta, tb_v, ts, tc, 0, rs, rc, ro, lat);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(rs), 32'(es));
        check({tag, "_cout"}, 32'(rc), 32'(ec));
        check({tag, "_ovf"}, 32'(ro), 32'(eo));
    endtask

    initial begin
        logic [15:0] rs;
        logic        rc;
        logic        ro;
        logic [17:0] exp;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rsb;
        logic        rci;
        int          lat;

        rst = 1'b1; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready_o[0]), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_outs", {13'd0, out_valid_o[0], cout_o[0], ovf_o[0], sum_o[0]}, 32'd0);
        check("post_rst_in_ready", 32'(in_ready_o[0]), 32'd1);

        directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Reset held three cycles while idle must clear the held result
        tick();
        rst = 1'b1;
        tick();
        check("idle_rst_in_ready", 32'(in_ready_o[0]), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_rst_outs", {13'd0, out_valid_o[0], cout_o[0], ovf_o[0], sum_o[0]}, 32'd0);
        check("idle_rst_in_ready", 32'(in_ready_o[0]), 32'd1);

        directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        directed("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
        directed("add_cin", 16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0);

        // Backpressure with new operands pending on the input side
        wait_ready(0);
        a = 16'h7FFF; b = 16'h0001; sub = 1'b0; cin = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        a = 16'h1111; b = 16'h2222;
        lat = 0;
        wait_valid(0, lat);
        check("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {12'd0, in_ready_o[0], out_valid_o[0], cout_o[0], ovf_o[0], sum_o[0]},
                  {12'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h8000});
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        check("bp_drain_in_ready", 32'(in_ready_o[0]), 32'd1);
        check("bp_drain_out_valid", 32'(out_valid_o[0]), 32'd0);
        tick();
        in_valid[0] = 1'b0;
        lat = 1;
        wait_valid(0, lat);
        check("bp_next_lat", 32'(lat), 32'd5);
        check("bp_next_sum", 32'(sum_o[0]), 32'h3333);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;

        // Reset after two CALC cycles discards the operation
        wait_ready(0);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; cin = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midop_rst_in_ready", 32'(in_ready_o[0]), 32'd0);
        rst = 1'b0;
        check("midop_rst_outs", {13'd0, out_valid_o[0], cout_o[0], ovf_o[0], sum_o[0]}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midop_no_valid", 32'(out_valid_o[0]), 32'd0);
        end
        directed("after_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        // Random sweep on the N=1 and N=16 instances
        for (int k = 1; k < 3; k++) begin
            for (int it = 0; it < 20; it++) begin
                ra  = 16'($urandom);
                rb  = 16'($urandom);
                rsb = 1'($urandom);
                rci = 1'($urandom);
                if (it == 0) begin ra = 16'h7FFF; rb = 16'h7FFF; rsb = 1'b0; rci = 1'b1; end
                if (it == 1) begin ra = 16'h8000; rb = 16'h7FFF; rsb = 1'b1; rci = 1'b0; end
                exp = model(ra, rb, rsb, rci);
                run_op(k, ra, rb, rsb, rci, int'($urandom_range(0, 3)), rs, rc, ro, lat);
                check("sweep_lat", 32'(lat), 32'(lat_of(k)));
                check("sweep_sum", 32'(rs), 32'(exp[15:0]));
                check("sweep_cout", 32'(rc), 32'(exp[16]));
                check("sweep_ovf", 32'(ro), 32'(exp[17]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
